// File: rtl/ulpi_pkg.sv
// Shared types for the ULPI receive framer: RX CMD layout, beat format, CRC helper.
// The CRC helper is only referenced when ULPI_RX_CRC16_CHECK_EN is defined.
package ulpi_pkg;

   typedef enum logic [1:0] {
      EV_NONE   = 2'b00,
      EV_ACTIVE = 2'b01,
      EV_DISC   = 2'b10,
      EV_ERR    = 2'b11
   } rx_event_e;

   typedef struct packed {
      logic       alt_int;
      logic       id;
      rx_event_e  rx_event;
      logic [1:0] vbus_state;
      logic [1:0] line_state;
   } rx_cmd_t;

   typedef struct packed {
      logic       first;
      logic       last;
      logic       err;
      logic [7:0] data;
   } rx_beat_t;

   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   // USB CRC16, data bits consumed LSB first
   function automatic logic [15:0] crc16_upd(input logic [15:0] crc,
                                             input logic [7:0]  d);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/ulpi_rx_fifo.sv
// Synchronous FIFO for received beats; pointers carry one wrap bit.
// Head word is read straight from storage, so valid never depends on pop.
module ulpi_rx_fifo
   import ulpi_pkg::*;
#(
   parameter int  DEPTH = 16,
   parameter type T     = rx_beat_t
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   T           mem [DEPTH];
   logic [AW:0] wr_q, rd_q;
   logic        do_pop, do_push;

   assign empty   = wr_q == rd_q;
   assign full    = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? T'('0) : mem[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ulpi_rx_framer.sv
// ULPI receive framer: RX CMD status decode, packet beat tagging, beat FIFO.
// Define ULPI_RX_CRC16_CHECK_EN to add PID and CRC16 checking on the last beat.
module ulpi_rx_framer
   import ulpi_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] sys_data,
   input  logic       sys_data_valid,
   input  logic [7:0] sys_rx_cmd,
   output logic [1:0] line_state,
   output logic [1:0] vbus_state,
   output logic       host_disconnect,
   output logic [7:0] pkt_data,
   output logic       pkt_first,
   output logic       pkt_last,
   output logic       pkt_err,
   output logic       pkt_valid,
   input  logic       pkt_ready,
   output logic       overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_TAIL,
      S_DROP
   } state_e;

   state_e     state_q, state_d;
   rx_cmd_t    cmd, cmd_q;
   logic [7:0] hold_q, hold_d;
   logic       hold_vld_q, hold_vld_d;
   logic       first_q, first_d;
   logic       err_q, err_d;
   logic       end_q, end_d;
   logic       ovf_q, ovf_d;
   logic       rx_active, rx_err, rise;
   logic       push, pop, can_push, full, empty;
   rx_beat_t   beat, beat_chk, head;
   logic       unused_ok;

   assign cmd       = rx_cmd_t'(sys_rx_cmd);
   assign rx_active = cmd.rx_event[0];
   assign rx_err    = cmd.rx_event == EV_ERR;
   assign rise      = rx_active & ~cmd_q.rx_event[0];
   assign pop       = pkt_ready & ~empty;
   assign can_push  = ~full | pop;
   assign unused_ok = ^{cmd_q.alt_int, cmd_q.id};

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      first_d    = first_q;
      err_d      = err_q;
      end_d      = end_q;
      ovf_d      = ovf_q;
      push       = 1'b0;
      beat       = '0;
      unique case (state_q)
         S_IDLE: begin
            if (rise) begin
               state_d    = S_ACTIVE;
               first_d    = 1'b1;
               err_d      = rx_err;
               end_d      = 1'b0;
               hold_vld_d = 1'b0;
            end
         end
         S_ACTIVE: begin
            if (rx_err) err_d = 1'b1;
            if (!rx_active) begin
               if (sys_data_valid && hold_vld_q) begin
                  // two bytes to retire: held one now, new one next cycle
                  beat = '{first: first_q, last: 1'b0,
                           err: 1'b0, data: hold_q};
                  push       = 1'b1;
                  hold_d     = sys_data;
                  first_d    = 1'b0;
                  state_d    = S_TAIL;
               end else if (sys_data_valid || hold_vld_q) begin
                  beat = '{first: first_q, last: 1'b1, err: err_q,
                           data: sys_data_valid ? sys_data : hold_q};
                  push       = 1'b1;
                  hold_vld_d = 1'b0;
                  first_d    = 1'b0;
                  state_d    = S_IDLE;
               end else begin
                  state_d    = S_IDLE;
               end
            end else if (sys_data_valid) begin
               if (hold_vld_q) begin
                  beat = '{first: first_q, last: 1'b0,
                           err: 1'b0, data: hold_q};
                  push    = 1'b1;
                  first_d = 1'b0;
               end
               hold_d     = sys_data;
               hold_vld_d = 1'b1;
            end
            if (push && !can_push) begin
               push       = 1'b0;
               ovf_d      = 1'b1;
               err_d      = 1'b1;
               hold_vld_d = 1'b0;
               end_d      = !rx_active;
               state_d    = S_DROP;
            end
         end
         S_TAIL: begin
            beat = '{first: first_q, last: 1'b1, err: err_q, data: hold_q};
            hold_vld_d = 1'b0;
            if (!can_push) begin
               ovf_d   = 1'b1;
               err_d   = 1'b1;
               end_d   = 1'b1;
               state_d = S_DROP;
            end else begin
               push = 1'b1;
               if (rx_active) begin
                  state_d = S_ACTIVE;
                  first_d = 1'b1;
                  err_d   = rx_err;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DROP: begin
            hold_vld_d = 1'b0;
            if (end_q || !rx_active) begin
               end_d = 1'b1;
               if (can_push) begin
                  beat = '{first: 1'b0, last: 1'b1,
                           err: 1'b1, data: 8'h00};
                  push  = 1'b1;
                  end_d = 1'b0;
                  if (end_q && rx_active) begin
                     state_d = S_ACTIVE;
                     first_d = 1'b1;
                     err_d   = rx_err;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         first_q    <= 1'b0;
         err_q      <= 1'b0;
         end_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         first_q    <= first_d;
         err_q      <= err_d;
         end_q      <= end_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef ULPI_RX_CRC16_CHECK_EN
   logic [7:0]  pid_q, pid;
   logic [15:0] crc_q, crc_nx;
   logic        chk_err;

   always_comb begin
      pid     = beat.first ? beat.data : pid_q;
      crc_nx  = beat.first ? 16'hFFFF : crc16_upd(crc_q, beat.data);
      chk_err = (pid[7:4] != ~pid[3:0]) |
                ((pid[1:0] == 2'b11) & (crc_nx != CRC16_RESIDUAL));
      beat_chk     = beat;
      beat_chk.err = beat.err | (beat.last & chk_err);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pid_q <= '0;
         crc_q <= 16'hFFFF;
      end else if (push) begin
         pid_q <= pid;
         crc_q <= crc_nx;
      end
   end
`else
   assign beat_chk = beat;
`endif

   ulpi_rx_fifo #(
      .DEPTH (DEPTH),
      .T     (rx_beat_t)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     (beat_chk),
      .pop     (pop),
      .dout    (head),
      .full    (full),
      .empty   (empty)
   );

   assign line_state      = cmd_q.line_state;
   assign vbus_state      = cmd_q.vbus_state;
   assign host_disconnect = cmd_q.rx_event == EV_DISC;
   assign pkt_data        = head.data;
   assign pkt_first       = head.first;
   assign pkt_last        = head.last;
   assign pkt_err         = head.err;
   assign pkt_valid       = ~empty;
   assign overflow        = ovf_q;

endmodule
